w0rm_mem_copy_initiator: RTL

- Bus initiator (DMA-style block copier) for the W0RM single-port memory interface: the master end of the valid/read/write/addr/data/user protocol that memory peripherals respond to.
- Copies count_i words from src_addr_i to dst_addr_i: one read, then one write per word, with one outstanding transaction.
- Sits between a control register peripheral and a memory block port.
- Uses the user sideband as a transaction tag to check responses.

---
 rtl/w0rm_mem_copy_initiator.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/w0rm_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// Module   : w0rm_mem_copy_initiator
// Purpose  : DMA-style block copier acting as a W0RM memory bus initiator.
//            Copies count_i words from src_addr_i to dst_addr_i. Each word is
//            one read followed by one write, with a single transaction in
//            flight. The user sideband carries the word index as a tag, and
//            every response tag is checked against it.
// Options  : W0RM_MEM_COPY_TIMEOUT_EN - abort with error when a response
//            does not arrive within TIMEOUT_CYCLES wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module w0rm_mem_copy_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   mem_clk,
    input  logic                   cpu_reset_n,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  src_addr_i,
    input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [COUNT_WIDTH-1:0] words_done_o,
    output logic                   mem_valid_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_data_o,
    output logic [USER_WIDTH-1:0]  mem_user_o,
    input  logic                   mem_valid_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [USER_WIDTH-1:0]  mem_user_i
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_req  = 3'd1;
    localparam logic [2:0] c_st_rd_wait = 3'd2;
    localparam logic [2:0] c_st_wr_req  = 3'd3;
    localparam logic [2:0] c_st_wr_wait = 3'd4;
    localparam logic [2:0] c_st_finish  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [2:0]             state_q,      state_d;
    logic [ADDR_WIDTH-1:0]  src_q,        src_d;
    logic [ADDR_WIDTH-1:0]  dst_q,        dst_d;
    logic [COUNT_WIDTH-1:0] count_q,      count_d;
    logic [DATA_WIDTH-1:0]  data_q,       data_d;
    logic [COUNT_WIDTH-1:0] words_done_q, words_done_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   error_q,      error_d;
    logic                   mem_valid_q,  mem_valid_d;
    logic                   mem_read_q,   mem_read_d;
    logic                   mem_write_q,  mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_data_q,   mem_data_d;
    logic [USER_WIDTH-1:0]  mem_user_q,   mem_user_d;

    // One extra bit so the "more words left" compare cannot overflow at
    // the maximum count.
    logic [COUNT_WIDTH:0]   w_words_next;
    logic                   w_more_words;
    logic                   w_tag_match;

    assign w_words_next = {1'b0, words_done_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign w_more_words = (w_words_next < {1'b0, count_q});
    // mem_user_q still holds the tag of the outstanding request.
    assign w_tag_match  = (mem_user_i == mem_user_q);

`ifdef W0RM_MEM_COPY_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] w_wait_cnt_inc;
    logic        w_wait_expire;

    assign w_wait_cnt_inc = wait_cnt_q + 32'd1;
    assign w_wait_expire  = (w_wait_cnt_inc == 32'(TIMEOUT_CYCLES));
`else
    // Without the timeout the limit has no effect; it is only kept so both
    // builds share one parameter list.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    // Next-state and next-output computation for the copy sequencer.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        count_d      = count_q;
        data_d       = data_q;
        words_done_d = words_done_q;
        busy_d       = busy_q;
        error_d      = error_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_user_d   = mem_user_q;
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        case (state_q)
            c_st_idle: begin
                if (start_i) begin
                    src_d        = src_addr_i;
                    dst_d        = dst_addr_i;
                    count_d      = count_i;
                    error_d      = 1'b0;
                    words_done_d = '0;
                    busy_d       = 1'b1;
                    state_d      = (count_i == '0) ? c_st_finish : c_st_rd_req;
                end
            end
            c_st_rd_req: begin
                state_d = c_st_rd_wait;
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            c_st_rd_wait: begin
                if (mem_valid_i) begin
                    if (w_tag_match) begin
                        data_d  = mem_data_i;
                        state_d = c_st_wr_req;
                    end else begin
                        error_d = 1'b1;
                        state_d = c_st_finish;
                    end
                end
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
                else if (w_wait_expire) begin
                    error_d = 1'b1;
                    state_d = c_st_finish;
                end else begin
                    wait_cnt_d = w_wait_cnt_inc;
                end
`endif
            end
            c_st_wr_req: begin
                state_d = c_st_wr_wait;
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            c_st_wr_wait: begin
                if (mem_valid_i) begin
                    if (w_tag_match) begin
                        words_done_d = w_words_next[COUNT_WIDTH-1:0];
                        src_d        = src_q + c_addr_step;
                        dst_d        = dst_q + c_addr_step;
                        state_d      = w_more_words ? c_st_rd_req : c_st_finish;
                    end else begin
                        error_d = 1'b1;
                        state_d = c_st_finish;
                    end
                end
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
                else if (w_wait_expire) begin
                    error_d = 1'b1;
                    state_d = c_st_finish;
                end else begin
                    wait_cnt_d = w_wait_cnt_inc;
                end
`endif
            end
            c_st_finish: begin
                busy_d  = 1'b0;
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Bus outputs are registered and loaded on entry to the request
        // states, so address/data/tag naturally hold through the waits.
        mem_valid_d = (state_d == c_st_rd_req) || (state_d == c_st_wr_req);
        mem_read_d  = (state_d == c_st_rd_req);
        mem_write_d = (state_d == c_st_wr_req);
        if (state_d == c_st_rd_req) begin
            mem_addr_d = src_d;
            mem_user_d = USER_WIDTH'(words_done_d);
        end
        if (state_d == c_st_wr_req) begin
            mem_addr_d = dst_d;
            mem_data_d = data_d;
        end
        done_d = (state_d == c_st_finish);
    end

    // State and output registers; reset aborts any copy without a done pulse.
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q      <= c_st_idle;
            src_q        <= '0;
            dst_q        <= '0;
            count_q      <= '0;
            data_q       <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_user_q   <= '0;
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            count_q      <= count_d;
            data_q       <= data_d;
            words_done_q <= words_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            mem_valid_q  <= mem_valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_user_q   <= mem_user_d;
`ifdef W0RM_MEM_COPY_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_done_o = words_done_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_user_o   = mem_user_q;

endmodule
`default_nettype wire
